uart_tx_frame: RTL

Parametrised UART transmitter and the next generation of the single-format 8N1 transmitter. It supports run-time selection of baud divisor, parity mode and stop-bit count, a valid/ready byte input, and a one-entry holding register so frames go out back-to-back. It sits between the tester's command/result logic and the board TX pin, clocked by the 27 MHz system clock.

---
 rtl/uart_tx_frame_pkg.sv | 45 ++++
 rtl/uart_tx_frame_if.sv | 32 +++
 rtl/uart_tx_frame_baud_cnt.sv | 40 ++++
 rtl/uart_tx_frame.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared types and helpers for the UART transmit/receive blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int unsigned SYS_CLK_HZ = 27_000_000;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_e;

    // Rounded clocks-per-bit for a baud rate at the system clock.
    function automatic int unsigned clks_per_bit(input int unsigned baud);
        if (baud == 0) begin
            return 0;
        end
        return (SYS_CLK_HZ + baud / 2) / baud;
    endfunction

    // Mode code 3 is treated as "no parity".
    function automatic parity_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_if : byte handshake, frame configuration and line outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
);
    logic [DATA_BITS-1:0] i_data;
    logic                 i_valid;
    logic                 o_ready;
    logic [DIV_W-1:0]     i_clks_per_bit;
    logic [1:0]           i_parity;
    logic                 i_two_stop;
    logic                 o_tx;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        output i_data, i_valid, i_clks_per_bit, i_parity, i_two_stop,
        input  o_ready, o_tx, o_busy, o_done
    );

    modport slave (
        input  i_data, i_valid, i_clks_per_bit, i_parity, i_two_stop,
        output o_ready, o_tx, o_busy, o_done
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_frame_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt : per-bit down-counter with end and one-before-end strobes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_baud_cnt #(
    parameter int DIV_W = 16
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    input  wire logic             i_load,
    input  wire logic             i_run,
    input  wire logic [DIV_W-1:0] i_div,
    output logic                  o_bit_end,
    output logic                  o_bit_near_end
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_div_clamped;

    // A bit shorter than two clocks would leave no room for the early strobe.
    assign w_div_clamped = (i_div < DIV_W'(2)) ? DIV_W'(2) : i_div;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_div_clamped - DIV_W'(1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_bit_end      = i_run & (r_cnt == '0);
    assign o_bit_near_end = i_run & (r_cnt == DIV_W'(1));

endmodule

`default_nettype wire

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame : UART transmitter with run-time divisor/parity/stop config
// and a one-entry holding register for back-to-back frames.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 234
) (
    input  wire logic        i_sys_clk,
    input  wire logic        i_rst_n,
    uart_tx_frame_if.slave   bus
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    parity_e              r_par_mode;
    logic                 r_par_bit;
    logic                 r_two_stop;
    logic [DIV_W-1:0]     r_div;
    logic                 r_tx;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_last_stop;
    logic                 w_frame_load;
    logic                 w_bit_start;
    logic                 w_run;
    logic                 w_bit_end;
    logic                 w_bit_near_end;
    logic [DIV_W-1:0]     w_cnt_div;
    parity_e              w_par_mode;

    assign w_accept    = bus.i_valid & ~r_hold_full;
    assign w_run       = (r_state != ST_IDLE);
    assign w_last_stop = (r_state == ST_STOP2) |
                         ((r_state == ST_STOP1) & ~r_two_stop);

    // A new frame starts from IDLE, or straight out of the final stop bit.
    assign w_frame_load = r_hold_full &
                          ((r_state == ST_IDLE) | (w_last_stop & w_bit_end));
    assign w_bit_start  = w_frame_load |
                          (w_run & w_bit_end & ~w_last_stop);
    assign w_cnt_div    = w_frame_load ? bus.i_clks_per_bit : r_div;
    assign w_par_mode   = decode_parity(bus.i_parity);

    uart_baud_cnt #(
        .DIV_W (DIV_W)
    ) u_baud_cnt (
        .i_clk          (i_sys_clk),
        .i_rst_n        (i_rst_n),
        .i_load         (w_bit_start),
        .i_run          (w_run),
        .i_div          (w_cnt_div),
        .o_bit_end      (w_bit_end),
        .o_bit_near_end (w_bit_near_end)
    );

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_par_mode  <= PAR_NONE;
            r_par_bit   <= 1'b0;
            r_two_stop  <= 1'b0;
            r_div       <= DIV_W'(DEFAULT_DIV);
            r_tx        <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            // Raised one clock early so the pulse lands on the last stop clock.
            r_done <= w_last_stop & w_bit_near_end;

            // Accept wins over the load release so a word is never dropped.
            if (w_frame_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_accept) begin
                r_hold      <= bus.i_data;
                r_hold_full <= 1'b1;
            end

            if (w_frame_load) begin
                r_state    <= ST_START;
                r_shift    <= r_hold;
                r_bit_idx  <= '0;
                r_par_mode <= w_par_mode;
                r_par_bit  <= (^r_hold) ^ (w_par_mode == PAR_ODD);
                r_two_stop <= bus.i_two_stop;
                r_div      <= bus.i_clks_per_bit;
                r_tx       <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    ST_START: begin
                        if (w_bit_end) begin
                            r_state <= ST_DATA;
                            r_tx    <= r_shift[0];
                        end
                    end
                    ST_DATA: begin
                        if (w_bit_end) begin
                            if (r_bit_idx == c_LAST_IDX) begin
                                if (r_par_mode == PAR_NONE) begin
                                    r_state <= ST_STOP1;
                                    r_tx    <= 1'b1;
                                end else begin
                                    r_state <= ST_PARITY;
                                    r_tx    <= r_par_bit;
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + IDX_W'(1);
                                r_shift   <= r_shift >> 1;
                                r_tx      <= r_shift[1];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_bit_end) begin
                            r_state <= ST_STOP1;
                            r_tx    <= 1'b1;
                        end
                    end
                    ST_STOP1: begin
                        if (w_bit_end) begin
                            r_state <= r_two_stop ? ST_STOP2 : ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end
                    ST_STOP2: begin
                        if (w_bit_end) begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.o_ready = ~r_hold_full;
    assign bus.o_busy  = w_run | r_hold_full;
    assign bus.o_tx    = r_tx;
    assign bus.o_done  = r_done;

endmodule

`default_nettype wire
